// File: rtl/frame_serializer_pkg.sv
// Shared types, constants and width helpers for the frame serializer and its CRC unit.
package frame_serializer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DROP     = 3'd1,
      ST_PREAMBLE = 3'd2,
      ST_SFD      = 3'd3,
      ST_LENGTH   = 3'd4,
      ST_PAYLOAD  = 3'd5,
      ST_FCS      = 3'd6
   } state_e;

   localparam logic [7:0]  DEFAULT_SFD     = 8'hA7;
   localparam logic [15:0] CRC16_POLY      = 16'h1021;
   // Bit-reversed form of CRC16_POLY, for a register that shifts toward bit 0.
   localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
   localparam int          FCS_BITS        = 16;

   function automatic int len_width(input int max_len);
      return $clog2(max_len + 32'sd1);
   endfunction

   function automatic int ptr_width(input int max_len);
      if (max_len > 32'sd1) begin
         return $clog2(max_len);
      end else begin
         return 32'sd1;
      end
   endfunction

   function automatic int bit_cnt_width(input int preamble_bits, input int data_w);
      int m;
      m = preamble_bits;
      if (data_w > m) begin
         m = data_w;
      end
      if (FCS_BITS > m) begin
         m = FCS_BITS;
      end
      return $clog2(m);
   endfunction

   // One serial CRC-16 step; the register shifts toward bit 0 so bit 0 leaves first.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
      logic [15:0] shifted;
      shifted = {1'b0, crc[15:1]};
      if ((crc[0] ^ b) == 1'b1) begin
         return shifted ^ CRC16_POLY_REFL;
      end else begin
         return shifted;
      end
   endfunction

endpackage

// File: rtl/frame_serializer_crc16_serial.sv
// Bit-serial CRC-16 (x^16+x^12+x^5+1, init 0, no final XOR). Used only with FRAME_SERIALIZER_FCS_EN.
module crc16_serial
   import frame_serializer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        enable_i,
   input  logic        bit_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   // Next CRC value: clear has priority over update.
   always_comb begin
      crc_d = crc_q;
      if (clear_i) begin
         crc_d = 16'h0000;
      end else if (enable_i) begin
         crc_d = crc16_step(crc_q, bit_i);
      end else begin
         crc_d = crc_q;
      end
   end

   // CRC register.
   always_ff @(posedge clk) begin
      if (reset) begin
         crc_q <= 16'h0000;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/frame_serializer.sv
// Buffers one PSDU frame, then serialises preamble, SFD, length, payload (and FCS) one bit per clock.
// Optional FCS generation is enabled by defining FRAME_SERIALIZER_FCS_EN.
module frame_serializer
   import frame_serializer_pkg::*;
#(
   parameter int                DATA_W        = 8,
   parameter int                PREAMBLE_BITS = 32,
   parameter logic [DATA_W-1:0] SFD           = DATA_W'(DEFAULT_SFD),
   parameter int                MAX_LEN       = 127
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic              ser_out,
   output logic              ser_out_valid,
   output logic              ser_sof,
   output logic              busy,
   output logic              frame_drop
);

   localparam int LEN_W = len_width(MAX_LEN);
   localparam int PTR_W = ptr_width(MAX_LEN);
   localparam int BIT_W = bit_cnt_width(PREAMBLE_BITS, DATA_W);
   localparam int IDX_W = $clog2(DATA_W);

   localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
   localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_BITS - 1);
   localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(DATA_W - 1);
`ifdef FRAME_SERIALIZER_FCS_EN
   localparam logic [BIT_W-1:0] FCS_LAST  = BIT_W'(FCS_BITS - 1);
`endif

   state_e            state_q, state_d;
   logic [BIT_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [MAX_LEN];

   logic in_ready_q, in_ready_d;
   logic ser_out_q, ser_out_d;
   logic ser_out_valid_q, ser_out_valid_d;
   logic ser_sof_q, ser_sof_d;
   logic busy_q, busy_d;
   logic frame_drop_q, frame_drop_d;

   logic              accept_s;
   logic              wr_en_s;
   logic [DATA_W-1:0] hdr_s;
   logic [IDX_W-1:0]  word_bit_s;

   assign accept_s   = in_valid && in_ready_q;
   assign wr_en_s    = (state_q == ST_IDLE) && accept_s && (len_q != MAX_LEN_C);
   assign word_bit_s = cnt_d[IDX_W-1:0];

`ifdef FRAME_SERIALIZER_FCS_EN
   logic [15:0] crc_s;

   assign hdr_s = DATA_W'(len_q) + DATA_W'(2);

   // CRC follows exactly the payload bits loaded into ser_out_q.
   crc16_serial u_crc (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (state_d == ST_PREAMBLE),
      .enable_i (state_d == ST_PAYLOAD),
      .bit_i    (ser_out_d),
      .crc_o    (crc_s)
   );
`else
   assign hdr_s = DATA_W'(len_q);
`endif

   // Frame sequencing: state, bit counter, word count and read pointer.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      rd_ptr_d     = rd_ptr_q;
      frame_drop_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               if (len_q == MAX_LEN_C) begin
                  frame_drop_d = 1'b1;
                  if (in_last) begin
                     len_d = '0;
                  end else begin
                     state_d = ST_DROP;
                  end
               end else begin
                  len_d = len_q + LEN_W'(1);
                  if (in_last) begin
                     state_d = ST_PREAMBLE;
                     cnt_d   = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (accept_s && in_last) begin
               state_d = ST_IDLE;
               len_d   = '0;
            end else begin
               state_d = ST_DROP;
            end
         end
         ST_PREAMBLE: begin
            if (cnt_q == PRE_LAST) begin
               state_d = ST_SFD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + BIT_W'(1);
            end
         end
         ST_SFD: begin
            if (cnt_q == WORD_LAST) begin
               state_d = ST_LENGTH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + BIT_W'(1);
            end
         end
         ST_LENGTH: begin
            if (cnt_q == WORD_LAST) begin
               state_d  = ST_PAYLOAD;
               cnt_d    = '0;
               rd_ptr_d = '0;
            end else begin
               cnt_d = cnt_q + BIT_W'(1);
            end
         end
         ST_PAYLOAD: begin
            if (cnt_q == WORD_LAST) begin
               cnt_d = '0;
               if (rd_ptr_q == (len_q - LEN_W'(1))) begin
`ifdef FRAME_SERIALIZER_FCS_EN
                  state_d = ST_FCS;
`else
                  state_d  = ST_IDLE;
                  len_d    = '0;
                  rd_ptr_d = '0;
`endif
               end else begin
                  rd_ptr_d = rd_ptr_q + LEN_W'(1);
               end
            end else begin
               cnt_d = cnt_q + BIT_W'(1);
            end
         end
`ifdef FRAME_SERIALIZER_FCS_EN
         ST_FCS: begin
            if (cnt_q == FCS_LAST) begin
               state_d  = ST_IDLE;
               cnt_d    = '0;
               len_d    = '0;
               rd_ptr_d = '0;
            end else begin
               cnt_d = cnt_q + BIT_W'(1);
            end
         end
`endif
         default: begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            len_d    = '0;
            rd_ptr_d = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with it once registered.
   always_comb begin
      in_ready_d      = 1'b0;
      ser_out_d       = 1'b0;
      ser_out_valid_d = 1'b0;
      ser_sof_d       = 1'b0;
      case (state_d)
         ST_IDLE, ST_DROP: begin
            in_ready_d = 1'b1;
         end
         ST_PREAMBLE: begin
            ser_out_valid_d = 1'b1;
            ser_out_d       = ~cnt_d[0];
            if (state_q == ST_IDLE) begin
               ser_sof_d = 1'b1;
            end else begin
               ser_sof_d = 1'b0;
            end
         end
         ST_SFD: begin
            ser_out_valid_d = 1'b1;
            ser_out_d       = SFD[word_bit_s];
         end
         ST_LENGTH: begin
            ser_out_valid_d = 1'b1;
            ser_out_d       = hdr_s[word_bit_s];
         end
         ST_PAYLOAD: begin
            ser_out_valid_d = 1'b1;
            ser_out_d       = mem_q[rd_ptr_d[PTR_W-1:0]][word_bit_s];
         end
`ifdef FRAME_SERIALIZER_FCS_EN
         ST_FCS: begin
            ser_out_valid_d = 1'b1;
            ser_out_d       = crc_s[cnt_d[3:0]];
         end
`endif
         default: begin
            in_ready_d = 1'b0;
         end
      endcase
      busy_d = ser_out_valid_d;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         len_q           <= '0;
         rd_ptr_q        <= '0;
         in_ready_q      <= 1'b0;
         ser_out_q       <= 1'b0;
         ser_out_valid_q <= 1'b0;
         ser_sof_q       <= 1'b0;
         busy_q          <= 1'b0;
         frame_drop_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         len_q           <= len_d;
         rd_ptr_q        <= rd_ptr_d;
         in_ready_q      <= in_ready_d;
         ser_out_q       <= ser_out_d;
         ser_out_valid_q <= ser_out_valid_d;
         ser_sof_q       <= ser_sof_d;
         busy_q          <= busy_d;
         frame_drop_q    <= frame_drop_d;
      end
   end

   // Payload buffer; contents are don't-care once len clears.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[len_q[PTR_W-1:0]] <= in_data;
      end
   end

   assign in_ready      = in_ready_q;
   assign ser_out       = ser_out_q;
   assign ser_out_valid = ser_out_valid_q;
   assign ser_sof       = ser_sof_q;
   assign busy          = busy_q;
   assign frame_drop    = frame_drop_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed self-checking bench for frame_serializer (MAX_LEN=4); honours FRAME_SERIALIZER_FCS_EN.
module tb_frame_serializer;

   localparam int PRE  = 32;
   localparam int MAXL = 4;
`ifdef FRAME_SERIALIZER_FCS_EN
   localparam int FCS_EXTRA = 16;
   localparam int HDR_ADD   = 2;
`else
   localparam int FCS_EXTRA = 0;
   localparam int HDR_ADD   = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready, ser_out, ser_out_valid, ser_sof, busy, frame_drop;

   int   n_checks = 0;
   int   n_fails = 0;
   logic cap[$];
   logic exp_q[$];
   logic [7:0] wbuf[$];
   int   sof_cnt = 0;
   int   drop_cnt = 0;
   int   rise_cnt = 0;
   logic prev_v = 1'b0;

   frame_serializer #(.DATA_W(8), .PREAMBLE_BITS(PRE), .SFD(8'hA7), .MAX_LEN(MAXL)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .ser_out(ser_out), .ser_out_valid(ser_out_valid),
      .ser_sof(ser_sof), .busy(busy), .frame_drop(frame_drop)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ser_out_valid === 1'b1) cap.push_back(ser_out);
      if (ser_out_valid === 1'b1 && prev_v !== 1'b1) rise_cnt++;
      prev_v = ser_out_valid;
      if (ser_sof === 1'b1) sof_cnt++;
      if (frame_drop === 1'b1) drop_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      cap.delete();
      sof_cnt = 0;
      drop_cnt = 0;
      rise_cnt = 0;
   endtask

   task automatic send_word(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (in_ready !== 1'b1 && n < 1000) begin
         tick();
         n++;
      end
      if (n >= 1000) begin
         n_checks++;
         n_fails++;
         $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame();
      for (int i = 0; i < wbuf.size(); i++) send_word(wbuf[i], (i == wbuf.size() - 1));
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 2000) begin
         tick();
         n++;
      end
      n_checks++;
      if (n >= 2000) begin
         n_fails++;
         $display("FAIL %s_idle_timeout: busy=%b, expected 0", name, busy);
      end
   endtask

   task automatic build_exp();
      logic [7:0] s;
      logic [7:0] h;
      s = 8'hA7;
      h = 8'(wbuf.size() + HDR_ADD);
      exp_q.delete();
      for (int i = 0; i < PRE; i++) exp_q.push_back((i % 2) == 0);
      for (int b = 0; b < 8; b++) exp_q.push_back(s[b]);
      for (int b = 0; b < 8; b++) exp_q.push_back(h[b]);
      foreach (wbuf[w]) for (int b = 0; b < 8; b++) exp_q.push_back(wbuf[w][b]);
   endtask

   function automatic int first_mismatch();
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i >= cap.size()) return i;
         if (cap[i] !== exp_q[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [15:0] residue(input int start);
      logic [15:0] c;
      logic fb;
      c = 16'h0000;
      for (int i = start; i < cap.size(); i++) begin
         fb = c[0] ^ cap[i];
         c = c >> 1;
         if (fb) c = c ^ 16'h8408;
      end
      return c;
   endfunction

   task automatic test_reset();
      repeat (3) tick();
      n_checks++;
      if ({in_ready, ser_out, ser_out_valid, ser_sof, busy, frame_drop} !== 6'b0) begin
         n_fails++;
         $display("FAIL reset_outputs: got %b, expected 000000",
                  {in_ready, ser_out, ser_out_valid, ser_sof, busy, frame_drop});
      end
      reset = 1'b0;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fails++;
         $display("FAIL reset_release_ready: in_ready=%b, expected 0", in_ready);
      end
      tick();
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL ready_after_reset: in_ready=%b, expected 1", in_ready);
      end
   endtask

   task automatic test_basic();
      int mm;
      clear_mon();
      wbuf = '{8'h01, 8'h02, 8'h03};
      send_frame();
      n_checks++;
      if ({ser_sof, ser_out_valid, busy, in_ready} !== 4'b1110) begin
         n_fails++;
         $display("FAIL basic_latency: sof/valid/busy/ready=%b, expected 1110",
                  {ser_sof, ser_out_valid, busy, in_ready});
      end
      wait_idle("basic");
      n_checks++;
      if ({in_ready, ser_out_valid} !== 2'b10) begin
         n_fails++;
         $display("FAIL basic_end: ready/valid=%b, expected 10", {in_ready, ser_out_valid});
      end
      build_exp();
      mm = first_mismatch();
      n_checks++;
      if (mm != -1) begin
         n_fails++;
         $display("FAIL basic_stream: first bad bit index %0d, expected none", mm);
      end
      n_checks++;
      if (cap.size() != 72 + FCS_EXTRA) begin
         n_fails++;
         $display("FAIL basic_valid_len: %0d cycles, expected %0d", cap.size(), 72 + FCS_EXTRA);
      end
      n_checks++;
      if (sof_cnt != 1 || rise_cnt != 1) begin
         n_fails++;
         $display("FAIL basic_sof: sof=%0d runs=%0d, expected 1 and 1", sof_cnt, rise_cnt);
      end
`ifdef FRAME_SERIALIZER_FCS_EN
      n_checks++;
      if (residue(48) !== 16'h0000) begin
         n_fails++;
         $display("FAIL basic_fcs_residue: got %h, expected 0000", residue(48));
      end
`endif
   endtask

   task automatic test_back_to_back();
      int n;
      int viol;
      int mm;
      clear_mon();
      wbuf = '{8'hC3, 8'h3C};
      send_frame();
      in_valid = 1'b1;
      in_data  = 8'h81;
      in_last  = 1'b1;
      n = 0;
      viol = 0;
      while (busy === 1'b1 && n < 1000) begin
         if (in_ready !== 1'b0) viol++;
         tick();
         n++;
      end
      n_checks++;
      if (viol != 0 || n != 64 + FCS_EXTRA) begin
         n_fails++;
         $display("FAIL b2b_ready_low: %0d ready cycles over %0d busy, expected 0 over %0d",
                  viol, n, 64 + FCS_EXTRA);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL b2b_no_gap: in_ready=%b when busy fell, expected 1", in_ready);
      end
      clear_mon();
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      n_checks++;
      if (ser_sof !== 1'b1) begin
         n_fails++;
         $display("FAIL b2b_second_sof: ser_sof=%b, expected 1", ser_sof);
      end
      wait_idle("b2b");
      wbuf = '{8'h81};
      build_exp();
      mm = first_mismatch();
      n_checks++;
      if (mm != -1 || cap.size() != 56 + FCS_EXTRA) begin
         n_fails++;
         $display("FAIL b2b_stream: bad bit %0d, len %0d, expected none and %0d",
                  mm, cap.size(), 56 + FCS_EXTRA);
      end
   endtask

   task automatic test_oversize();
      int mm;
      clear_mon();
      wbuf = '{8'h10, 8'h20, 8'h40, 8'h80};
      send_frame();
      wait_idle("maxlen");
      build_exp();
      mm = first_mismatch();
      n_checks++;
      if (mm != -1 || cap.size() != 80 + FCS_EXTRA) begin
         n_fails++;
         $display("FAIL maxlen_stream: bad bit %0d, len %0d, expected none and %0d",
                  mm, cap.size(), 80 + FCS_EXTRA);
      end
      clear_mon();
      for (int i = 0; i < 4; i++) send_word(8'(i + 1), 1'b0);
      n_checks++;
      if (frame_drop !== 1'b0) begin
         n_fails++;
         $display("FAIL drop_early: frame_drop=%b after 4th word, expected 0", frame_drop);
      end
      send_word(8'h05, 1'b0);
      n_checks++;
      if ({frame_drop, in_ready} !== 2'b11) begin
         n_fails++;
         $display("FAIL drop_pulse: drop/ready=%b after 5th word, expected 11", {frame_drop, in_ready});
      end
      send_word(8'h06, 1'b1);
      repeat (3) tick();
      n_checks++;
      if (drop_cnt != 1 || cap.size() != 0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_fails++;
         $display("FAIL drop_idle: drops=%0d bits=%0d busy=%b ready=%b, expected 1 0 0 1",
                  drop_cnt, cap.size(), busy, in_ready);
      end
      clear_mon();
      for (int i = 0; i < 4; i++) send_word(8'(i + 9), 1'b0);
      send_word(8'h0D, 1'b1);
      n_checks++;
      if ({frame_drop, in_ready} !== 2'b11) begin
         n_fails++;
         $display("FAIL drop_last: drop/ready=%b, expected 11", {frame_drop, in_ready});
      end
      repeat (3) tick();
      n_checks++;
      if (drop_cnt != 1 || cap.size() != 0) begin
         n_fails++;
         $display("FAIL drop_last_quiet: drops=%0d bits=%0d, expected 1 0", drop_cnt, cap.size());
      end
      clear_mon();
      wbuf = '{8'hF0, 8'h0F};
      send_frame();
      wait_idle("post_drop");
      build_exp();
      mm = first_mismatch();
      n_checks++;
      if (mm != -1 || cap.size() != 64 + FCS_EXTRA) begin
         n_fails++;
         $display("FAIL post_drop_stream: bad bit %0d, len %0d, expected none and %0d",
                  mm, cap.size(), 64 + FCS_EXTRA);
      end
   endtask

   task automatic test_reset_mid();
      int mm;
      clear_mon();
      wbuf = '{8'hAA, 8'hBB, 8'hCC};
      send_frame();
      repeat (52) tick();
      n_checks++;
      if (ser_out_valid !== 1'b1) begin
         n_fails++;
         $display("FAIL mid_active: ser_out_valid=%b in payload, expected 1", ser_out_valid);
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if ({in_ready, ser_out, ser_out_valid, ser_sof, busy, frame_drop} !== 6'b0) begin
         n_fails++;
         $display("FAIL mid_reset_outputs: got %b, expected 000000",
                  {in_ready, ser_out, ser_out_valid, ser_sof, busy, frame_drop});
      end
      reset = 1'b0;
      tick();
      clear_mon();
      wbuf = '{8'h5A};
      send_frame();
      wait_idle("post_reset");
      build_exp();
      mm = first_mismatch();
      n_checks++;
      if (mm != -1 || cap.size() != 56 + FCS_EXTRA || sof_cnt != 1) begin
         n_fails++;
         $display("FAIL post_reset_stream: bad bit %0d, len %0d, sof %0d, expected none, %0d, 1",
                  mm, cap.size(), 56 + FCS_EXTRA, sof_cnt);
      end
   endtask

   task automatic test_stall();
      logic       v_tab [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] d_tab [5] = '{8'h11, 8'hEE, 8'h22, 8'hEE, 8'h33};
      logic       l_tab [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      int mm;
      clear_mon();
      for (int i = 0; i < 5; i++) begin
         in_valid = v_tab[i];
         in_data  = d_tab[i];
         in_last  = l_tab[i];
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      n_checks++;
      if (ser_sof !== 1'b1 || sof_cnt != 0) begin
         n_fails++;
         $display("FAIL stall_start: sof=%b earlier sofs=%0d, expected 1 and 0", ser_sof, sof_cnt);
      end
      wait_idle("stall");
      wbuf = '{8'h11, 8'h22, 8'h33};
      build_exp();
      mm = first_mismatch();
      n_checks++;
      if (mm != -1 || cap.size() != 72 + FCS_EXTRA || sof_cnt != 1) begin
         n_fails++;
         $display("FAIL stall_stream: bad bit %0d, len %0d, sof %0d, expected none, %0d, 1",
                  mm, cap.size(), 72 + FCS_EXTRA, sof_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_oversize();
      test_reset_mid();
      test_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
